// File: rtl/ifid_pipe_reg_pkg.sv
// Shared opcode and FSM encodings for the IF/ID boundary.
package pipe_defs;
   localparam logic [4:0]  OPC_HALT  = 5'b00000;
   localparam logic [4:0]  OPC_NOP   = 5'b00001;
   localparam logic [15:0] NOP_INSTR = 16'h0800;

   localparam logic ST_RUN    = 1'b0;
   localparam logic ST_HALTED = 1'b1;
endpackage

// File: rtl/pipe_field_reg.sv
// Generic W-bit storage element: async reset to RST_VAL, sync clear to CLR_VAL, load on en.
// One cycle latency; clear wins over load.
module pipe_field_reg #(
   parameter int              W       = 1,
   parameter logic [W-1:0]    RST_VAL = '0,
   parameter logic [W-1:0]    CLR_VAL = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          clr,
   input  logic [W-1:0]  d,
   output logic [W-1:0]  q
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= RST_VAL;
      else if (clr)
         q <= CLR_VAL;
      else if (en)
         q <= d;
   end
endmodule

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register with stall hold, flush bubble, sticky HALT drain and stall counter.
// One cycle fetch->decode; stall freezes contents, flush overrides stall.
module ifid_pipe_reg
   import pipe_defs::*;
#(
   parameter int IW = 16,
   parameter int AW = 16,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          flush,
   input  logic [IW-1:0] if_instr,
   input  logic [AW-1:0] if_pc_inc,
   input  logic          if_err,
   output logic [IW-1:0] id_instr,
   output logic [AW-1:0] id_pc_inc,
   output logic          id_valid,
   output logic          id_err,
   output logic          fetch_hold,
   output logic [CW-1:0] stall_cnt
);
   logic state;
   logic halted;
   logic load;
   logic bubble;
   logic is_halt;
   logic enter_halt;

   assign halted     = (state == ST_HALTED);
   assign load       = ~flush & ~stall;
   // While halted, every would-be load becomes a bubble and fetch data is ignored.
   assign bubble     = flush | (load & halted);
   assign is_halt    = (if_instr[IW-1 -: 5] == OPC_HALT);
   assign enter_halt = load & ~halted & is_halt;
   assign fetch_hold = stall | halted;

   pipe_field_reg #(.W(IW), .RST_VAL(IW'(NOP_INSTR)), .CLR_VAL(IW'(NOP_INSTR))) u_instr (
      .clk(clk), .rst(rst), .en(load), .clr(bubble), .d(if_instr), .q(id_instr)
   );

   // PC+2 follows both flush and real loads, but is held across halted bubbles.
   pipe_field_reg #(.W(AW)) u_pc_inc (
      .clk(clk), .rst(rst), .en(flush | (load & ~halted)), .clr(1'b0),
      .d(if_pc_inc), .q(id_pc_inc)
   );

   pipe_field_reg #(.W(1)) u_valid (
      .clk(clk), .rst(rst), .en(load), .clr(bubble), .d(1'b1), .q(id_valid)
   );

   pipe_field_reg #(.W(1)) u_err (
      .clk(clk), .rst(rst), .en(load), .clr(bubble), .d(if_err), .q(id_err)
   );

   pipe_field_reg #(.W(1), .RST_VAL(ST_RUN), .CLR_VAL(ST_RUN)) u_state (
      .clk(clk), .rst(rst), .en(enter_halt), .clr(flush), .d(ST_HALTED), .q(state)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (stall && (stall_cnt != '1))
         stall_cnt <= stall_cnt + CW'(1);
   end
endmodule

// File: tb/tb_ifid_pipe_reg.sv
module tb_ifid_pipe_reg;
   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        flush;
   logic [15:0] if_instr;
   logic [15:0] if_pc_inc;
   logic        if_err;
   logic [15:0] id_instr;
   logic [15:0] id_pc_inc;
   logic        id_valid;
   logic        id_err;
   logic        fetch_hold;
   logic [15:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ifid_pipe_reg #(.IW(16), .AW(16), .CW(16)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .if_instr(if_instr), .if_pc_inc(if_pc_inc), .if_err(if_err),
      .id_instr(id_instr), .id_pc_inc(id_pc_inc), .id_valid(id_valid),
      .id_err(id_err), .fetch_hold(fetch_hold), .stall_cnt(stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      if_instr = 16'h0000; if_pc_inc = 16'h0000; if_err = 1'b0;
      step();
      chk("rst_instr", id_instr, 16'h0800);
      chk("rst_pc", id_pc_inc, 16'h0000);
      chk("rst_valid", id_valid, 1'b0);
      chk("rst_err", id_err, 1'b0);
      chk("rst_hold", fetch_hold, 1'b0);
      chk("rst_cnt", stall_cnt, 16'h0000);

      // 1: plain load
      rst = 1'b0;
      if_instr = 16'h4105; if_pc_inc = 16'h0002;
      step();
      chk("t1_instr", id_instr, 16'h4105);
      chk("t1_pc", id_pc_inc, 16'h0002);
      chk("t1_valid", id_valid, 1'b1);
      chk("t1_hold", fetch_hold, 1'b0);

      // 2: stall three edges with new fetch data presented
      stall = 1'b1; if_instr = 16'h6000; if_pc_inc = 16'h0004;
      #1;
      chk("t2_hold_comb", fetch_hold, 1'b1);
      step(); step(); step();
      chk("t2_instr", id_instr, 16'h4105);
      chk("t2_pc", id_pc_inc, 16'h0002);
      chk("t2_cnt", stall_cnt, 16'd3);
      chk("t2_hold", fetch_hold, 1'b1);

      // 3: flush beats stall, counter still counts
      flush = 1'b1;
      step();
      chk("t3_instr", id_instr, 16'h0800);
      chk("t3_valid", id_valid, 1'b0);
      chk("t3_pc", id_pc_inc, 16'h0004);
      chk("t3_cnt", stall_cnt, 16'd4);

      // fetch error is latched as a valid instruction
      stall = 1'b0; flush = 1'b0;
      if_instr = 16'h4105; if_pc_inc = 16'h0006; if_err = 1'b1;
      step();
      chk("err_valid", id_valid, 1'b1);
      chk("err_err", id_err, 1'b1);

      // 4: HALT latched, then bubbles
      if_instr = 16'h0000; if_pc_inc = 16'h0008; if_err = 1'b0;
      step();
      chk("t4_instr", id_instr, 16'h0000);
      chk("t4_valid", id_valid, 1'b1);
      chk("t4_hold", fetch_hold, 1'b1);
      if_instr = 16'h4105; if_pc_inc = 16'h000A; if_err = 1'b1;
      step();
      chk("t4_bub_instr", id_instr, 16'h0800);
      chk("t4_bub_valid", id_valid, 1'b0);
      chk("t4_bub_err", id_err, 1'b0);
      chk("t4_bub_pc", id_pc_inc, 16'h0008);
      chk("t4_bub_hold", fetch_hold, 1'b1);

      // 5: flush leaves HALTED
      flush = 1'b1; if_err = 1'b0;
      step();
      chk("t5_hold", fetch_hold, 1'b0);
      chk("t5_valid", id_valid, 1'b0);
      flush = 1'b0; if_instr = 16'h4105; if_pc_inc = 16'h000C;
      step();
      chk("t5_valid2", id_valid, 1'b1);
      chk("t5_instr", id_instr, 16'h4105);

      // HALT under flush or stall must not enter HALTED
      if_instr = 16'h0000; flush = 1'b1;
      step();
      chk("halt_flush_hold", fetch_hold, 1'b0);
      flush = 1'b0; stall = 1'b1;
      step();
      chk("halt_stall_cnt", stall_cnt, 16'd5);
      chk("halt_stall_instr", id_instr, 16'h0800);
      stall = 1'b0;
      #1;
      chk("halt_stall_hold", fetch_hold, 1'b0);

      // now a real HALT load: HALTED with stall_cnt=5
      step();
      chk("t6_pre_hold", fetch_hold, 1'b1);
      chk("t6_pre_cnt", stall_cnt, 16'd5);

      // 6: async reset mid-cycle
      #2;
      rst = 1'b1;
      #1;
      chk("t6_instr", id_instr, 16'h0800);
      chk("t6_valid", id_valid, 1'b0);
      chk("t6_pc", id_pc_inc, 16'h0000);
      chk("t6_cnt", stall_cnt, 16'h0000);
      chk("t6_hold", fetch_hold, 1'b0);
      step();
      rst = 1'b0;
      if_instr = 16'h4105; if_pc_inc = 16'h0002;
      step();
      chk("t6_after_valid", id_valid, 1'b1);

      // 7: counter saturation
      stall = 1'b1;
      repeat (65534) @(posedge clk);
      #1;
      chk("t7_fffe", stall_cnt, 16'hFFFE);
      step();
      chk("t7_ffff", stall_cnt, 16'hFFFF);
      step();
      chk("t7_sat", stall_cnt, 16'hFFFF);
      stall = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
